// File: rtl/processor_pio_pkg.sv
// processor_pio_pkg: register map and edge-type encodings shared by the PIO blocks
//   ADDR_*  : 2-bit word addresses of the slave register map
//   EDGE_*  : encodings of the EDGE_TYPE parameter
package processor_pio_pkg;
  typedef enum logic [1:0] {
    ADDR_DATA    = 2'd0,
    ADDR_RSVD    = 2'd1,
    ADDR_IRQMASK = 2'd2,
    ADDR_EDGECAP = 2'd3
  } pio_addr_e;
  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;
endpackage

// File: rtl/processor_pio_debounce.sv
// processor_pio_debounce: single-bit stability filter
//   clk, reset : clock, asynchronous active-high reset
//   load       : while high the output follows din directly (used before arming)
//   din        : synchronised input bit
//   dout       : filtered level, changes only after DEBOUNCE_CYCLES consecutive
//                samples that differ from the current level
module processor_pio_debounce import processor_pio_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic din,
  output logic dout
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic stable_q, stable_d;
  logic diff;
  // counter only runs while the input disagrees with the accepted level, so any
  // return to the old level restarts the window; it wraps to 0 on acceptance
  always_comb begin
    diff = din != stable_q;
    stable_d = load || (diff && cnt_q == LAST) ? din : stable_q;
    cnt_d = load || !diff || cnt_q == LAST ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt_q <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      stable_q <= stable_d;
    end
  assign dout = stable_q;
endmodule

// File: rtl/processor_button_pio.sv
// processor_button_pio: Avalon-MM input PIO with edge capture and level irq
//   clk, reset            : clock, asynchronous active-high reset
//   address, chipselect,
//   read_n, write_n,
//   writedata, readdata   : Avalon-MM slave, read latency 1
//   in_port               : asynchronous WIDTH-bit inputs
//   irq                   : |(EDGECAPTURE & IRQMASK), registered
// Optional per-bit debounce filter enabled by defining PIO_IN_DEBOUNCE_EN.
module processor_button_pio import processor_pio_pkg::*; #(
  parameter int WIDTH = 4,
  parameter int EDGE_TYPE = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read_n,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);
`ifdef PIO_IN_DEBOUNCE_EN
  localparam bit DB_EN = 1'b1;
`else
  localparam bit DB_EN = 1'b0;
`endif
  logic [WIDTH-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [WIDTH-1:0] level_q, level_d, prev_q, prev_d;
  logic [WIDTH-1:0] mask_q, mask_d, cap_q, cap_d;
  logic [2:0] arm_q, arm_d;
  logic irq_q, irq_d;
  logic [31:0] rdata_q, rdata_d, rword;
  logic [WIDTH-1:0] filt, rise, fall, hit, clr;
  logic armed, wr, rd;
  logic unused_wd;
  assign armed = arm_q[2];
  assign unused_wd = ^writedata;
  // a DEBOUNCE_CYCLES below 2 leaves nothing to filter, so fall back to bypass
  if (DB_EN && DEBOUNCE_CYCLES > 1) begin : g_db
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      processor_pio_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
        .clk(clk),
        .reset(reset),
        .load(~armed),
        .din(sync2_q[i]),
        .dout(filt[i])
      );
    end
  end else begin : g_nodb
    assign filt = sync2_q;
  end
  always_comb begin
    wr = chipselect & ~write_n;
    rd = chipselect & ~read_n;
    sync1_d = in_port;
    sync2_d = sync1_q;
    arm_d = {arm_q[1:0], 1'b1};
    // before arming, level takes the raw synchronised value and prev shadows it,
    // so the first armed comparison sees no edge for pins held through reset
    level_d = armed ? filt : sync2_q;
    prev_d = armed ? level_q : level_d;
    rise = level_q & ~prev_q;
    fall = ~level_q & prev_q;
    hit = !armed ? '0 :
          EDGE_TYPE == EDGE_RISING  ? rise :
          EDGE_TYPE == EDGE_FALLING ? fall : rise | fall;
    clr = wr && address == ADDR_EDGECAP ? writedata[WIDTH-1:0] : '0;
    // set has priority over a simultaneous write-1-to-clear
    cap_d = (cap_q & ~clr) | hit;
    mask_d = wr && address == ADDR_IRQMASK ? writedata[WIDTH-1:0] : mask_q;
    irq_d = |(cap_q & mask_q);
    rword = '0;
    rword[WIDTH-1:0] = address == ADDR_DATA    ? level_q :
                       address == ADDR_IRQMASK ? mask_q  :
                       address == ADDR_EDGECAP ? cap_q   : '0;
    rdata_d = rd ? rword : rdata_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      prev_q <= '0;
      arm_q <= '0;
      mask_q <= '0;
      cap_q <= '0;
      irq_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      prev_q <= prev_d;
      arm_q <= arm_d;
      mask_q <= mask_d;
      cap_q <= cap_d;
      irq_q <= irq_d;
      rdata_q <= rdata_d;
    end
  assign readdata = rdata_q;
  assign irq = irq_q;
endmodule
